// File: rtl/acc_host_pkg.sv
// Shared types and helpers for the accelerator host-side memory model.
// Holds the run-sequencer state encoding and the result checksum step.
package acc_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WR_COUNT_W = 32;
    localparam int CKS_MAX_W  = 256;

    // Rotate-left-by-one of the low w bits of c, then xor in d.
    function automatic logic [CKS_MAX_W-1:0] cks_step(
        input logic [CKS_MAX_W-1:0] c,
        input logic [CKS_MAX_W-1:0] d,
        input int                   w
    );
        logic [CKS_MAX_W-1:0] r;
        r    = '0;
        r[0] = c[8'(w-1)];
        for (int i = 1; i < CKS_MAX_W; i++) begin
            if (i < w) r[i] = c[8'(i-1)];
        end
        return r ^ d;
    endfunction

endpackage

// File: rtl/acc_host_ram.sv
// Simple dual-port RAM: one write port, one registered read port (latency 1).
// A same-cycle write and read of one address returns the previous word.
module acc_host_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/acc_host_mem.sv
// Host-side memory model for the accelerator: operand store, result capture and run sequencing.
// Optional ACC_HOST_CHECKSUM_EN adds a rotating-xor checksum output over accepted result writes.
module acc_host_mem
    import acc_host_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 23,
    parameter int IN_DEPTH       = 4096,
    parameter int RES_DEPTH      = 4096,
    parameter int ARM_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         host_start,
    input  logic                         host_ld_en,
    input  logic [$clog2(IN_DEPTH)-1:0]  host_ld_addr,
    input  logic [DATA_WIDTH-1:0]        host_ld_data,
    input  logic [$clog2(RES_DEPTH)-1:0] host_rd_addr,
    output logic [DATA_WIDTH-1:0]        host_rd_data,
    output logic                         comp_enb,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_read_enb,
    output logic [DATA_WIDTH-1:0]        mem_data,
    input  logic                         mem_write_enb,
    input  logic [ADDR_WIDTH-1:0]        res_addr,
    input  logic [DATA_WIDTH-1:0]        res_data,
    input  logic                         busyb,
    input  logic                         done,
    output logic                         run_busy,
    output logic                         run_done,
    output logic                         run_timeout,
    output logic                         addr_err,
    output logic [WR_COUNT_W-1:0]        wr_count
`ifdef ACC_HOST_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]        checksum
`endif
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int ARM_W  = $clog2(ARM_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ARM_W-1:0]    ARM_LAST = ARM_W'(ARM_CYCLES - 1);
    localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] IN_LIM   = (ADDR_WIDTH+1)'(IN_DEPTH);
    localparam logic [ADDR_WIDTH:0] RES_LIM  = (ADDR_WIDTH+1)'(RES_DEPTH);

    state_t           r_state, w_state_nxt;
    logic             w_arm_entry, w_to_hit;
    logic [ARM_W-1:0] r_arm_cnt;
    logic [TO_W-1:0]  r_to_cnt;

    logic w_in_run, w_rd_inr, w_wr_inr, w_wr_ok, w_wr_bad, w_rd_bad, w_ld_ok;
    logic r_rd_zero, r_hrd_vld;
    logic [DATA_WIDTH-1:0] w_op_q, w_res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arm_entry = 1'b0;
        w_to_hit    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (host_start) begin
                    w_state_nxt = ARM;
                    w_arm_entry = 1'b1;
                end
            end
            ARM: begin
                if (r_arm_cnt == ARM_LAST) w_state_nxt = RUN;
            end
            RUN: begin
                if (done) begin
                    w_state_nxt = DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = DONE;
                    w_to_hit    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_cnt <= '0;
            r_to_cnt  <= '0;
        end else if (w_arm_entry) begin
            r_arm_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == ARM) r_arm_cnt <= r_arm_cnt + 1'b1;
            if (r_state == RUN) r_to_cnt  <= r_to_cnt + 1'b1;
        end
    end

    assign w_in_run = (r_state == RUN);
    assign w_rd_inr = ({1'b0, mem_addr} < IN_LIM);
    assign w_wr_inr = ({1'b0, res_addr} < RES_LIM);
    assign w_wr_ok  = w_in_run & mem_write_enb & w_wr_inr;
    assign w_wr_bad = w_in_run & mem_write_enb & ~w_wr_inr;
    assign w_rd_bad = w_in_run & mem_read_enb & ~w_rd_inr;
    assign w_ld_ok  = host_ld_en & ((r_state == IDLE) | (r_state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_timeout <= 1'b0;
            addr_err    <= 1'b0;
            wr_count    <= '0;
        end else if (w_arm_entry) begin
            run_timeout <= 1'b0;
            addr_err    <= 1'b0;
            wr_count    <= '0;
        end else begin
            if (w_to_hit)              run_timeout <= 1'b1;
            if (w_wr_bad || w_rd_bad)  addr_err    <= 1'b1;
            if (w_wr_ok && (wr_count != '1)) wr_count <= wr_count + 1'b1;
        end
    end

    // Zero-masking flags let the data RAMs stay unreset while outputs still read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_zero <= 1'b1;
            r_hrd_vld <= 1'b0;
        end else begin
            if (mem_read_enb) r_rd_zero <= ~w_rd_inr;
            r_hrd_vld <= 1'b1;
        end
    end

    acc_host_ram #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_op_ram (
        .clk     (clk),
        .i_we    (w_ld_ok),
        .i_waddr (host_ld_addr),
        .i_wdata (host_ld_data),
        .i_re    (mem_read_enb & w_rd_inr),
        .i_raddr (mem_addr[IN_AW-1:0]),
        .o_rdata (w_op_q)
    );

    acc_host_ram #(.WIDTH(DATA_WIDTH), .DEPTH(RES_DEPTH)) u_res_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (res_addr[RES_AW-1:0]),
        .i_wdata (res_data),
        .i_re    (1'b1),
        .i_raddr (host_rd_addr),
        .o_rdata (w_res_q)
    );

    assign mem_data     = r_rd_zero ? '0 : w_op_q;
    assign host_rd_data = r_hrd_vld ? w_res_q : '0;
    assign comp_enb     = (r_state != RUN);
    assign run_busy     = (r_state == ARM) | (r_state == RUN);
    assign run_done     = (r_state == DONE);

`ifdef ACC_HOST_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_cks;
    logic [CKS_MAX_W-1:0]  w_cks_full;

    assign w_cks_full = cks_step(CKS_MAX_W'(r_cks), CKS_MAX_W'(res_data), DATA_WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_cks <= '0;
        else if (w_arm_entry) r_cks <= '0;
        else if (w_wr_ok)     r_cks <= w_cks_full[DATA_WIDTH-1:0];
    end

    assign checksum = r_cks;
`endif

endmodule

// File: tb/tb_acc_host_mem.sv
// Directed self-checking bench for acc_host_mem (ARM_CYCLES=4, TIMEOUT_CYCLES=50).
// Checksum checks are compiled in when ACC_HOST_CHECKSUM_EN is defined.
module tb_acc_host_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_start, host_ld_en;
    logic [11:0] host_ld_addr, host_rd_addr;
    logic [63:0] host_ld_data, host_rd_data;
    logic        comp_enb;
    logic [22:0] mem_addr, res_addr;
    logic        mem_read_enb, mem_write_enb;
    logic [63:0] mem_data, res_data;
    logic        busyb, done;
    logic        run_busy, run_done, run_timeout, addr_err;
    logic [31:0] wr_count;
`ifdef ACC_HOST_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    int n_pass = 0;
    int n_tot  = 0;
    int n_cyc;

    localparam logic [63:0] OPV = 64'h0123_4567_89AB_CDEF;

    always #5 clk = ~clk;

    acc_host_mem #(
        .DATA_WIDTH(64), .ADDR_WIDTH(23), .IN_DEPTH(4096), .RES_DEPTH(4096),
        .ARM_CYCLES(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host_start(host_start), .host_ld_en(host_ld_en),
        .host_ld_addr(host_ld_addr), .host_ld_data(host_ld_data),
        .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data), .comp_enb(comp_enb),
        .mem_addr(mem_addr), .mem_read_enb(mem_read_enb), .mem_data(mem_data),
        .mem_write_enb(mem_write_enb), .res_addr(res_addr), .res_data(res_data),
        .busyb(busyb), .done(done), .run_busy(run_busy), .run_done(run_done),
        .run_timeout(run_timeout), .addr_err(addr_err), .wr_count(wr_count)
`ifdef ACC_HOST_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_to_run();
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        repeat (4) tick();
    endtask

    task automatic wr(input logic [22:0] a, input logic [63:0] d);
        mem_write_enb = 1'b1;
        res_addr      = a;
        res_data      = d;
        tick();
        mem_write_enb = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; host_start = 0; host_ld_en = 0; host_ld_addr = 0; host_ld_data = 0;
        host_rd_addr = 0; mem_addr = 0; mem_read_enb = 0; mem_write_enb = 0;
        res_addr = 0; res_data = 0; busyb = 0; done = 0;
        repeat (2) tick();
        chk("rst_comp_enb", 64'(comp_enb), 64'd1);
        chk("rst_mem_data", mem_data, 64'd0);
        chk("rst_host_rd", host_rd_data, 64'd0);
        chk("rst_busy_done", {62'd0, run_busy, run_done}, 64'd0);
        chk("rst_flags", {62'd0, run_timeout, addr_err}, 64'd0);
        chk("rst_wr_count", 64'(wr_count), 64'd0);
        rst_n = 1'b1;
        tick();

        host_ld_en = 1'b1; host_ld_addr = 12'd5; host_ld_data = OPV;
        tick();
        host_ld_en = 1'b0;

        // ARM: comp_enb high for exactly four sampled cycles
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        chk("arm_comp_enb0", 64'(comp_enb), 64'd1);
        chk("arm_busy", 64'(run_busy), 64'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("arm_comp_enb%0d", i), 64'(comp_enb), 64'd1);
        end
        tick();
        chk("run_comp_enb", 64'(comp_enb), 64'd0);

        mem_read_enb = 1'b1; mem_addr = 23'd5;
        tick();
        chk("rd5_data", mem_data, OPV);
        chk("rd5_no_err", 64'(addr_err), 64'd0);
        mem_addr = 23'd4096;
        tick();
        mem_read_enb = 1'b0;
        chk("rd_oor_data", mem_data, 64'd0);
        chk("rd_oor_err", 64'(addr_err), 64'd1);

        wr(23'd0, 64'd10);
        wr(23'd1, 64'd20);
        wr(23'd2, 64'd30);
        wr(23'd5000, 64'd99);
        chk("wr_count3", 64'(wr_count), 64'd3);
        chk("wr_addr_err", 64'(addr_err), 64'd1);
        host_rd_addr = 12'd1;
        tick();
        chk("readback1", host_rd_data, 64'd20);

        host_ld_en = 1'b1; host_ld_addr = 12'd5; host_ld_data = 64'hDEAD_BEEF;
        tick();
        host_ld_en = 1'b0;
        mem_read_enb = 1'b1; mem_addr = 23'd5;
        tick();
        mem_read_enb = 1'b0;
        chk("ld_in_run_ignored", mem_data, OPV);

        done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_run_done", 64'(run_done), 64'd1);
        chk("done_comp_enb", 64'(comp_enb), 64'd1);
        chk("done_busy", 64'(run_busy), 64'd0);
        chk("done_no_timeout", 64'(run_timeout), 64'd0);

        // Second run: no done, expect timeout exactly 50 cycles after RUN entry
        start_to_run();
        chk("run2_cleared", {61'd0, comp_enb, addr_err, |wr_count}, 64'd0);
        n_cyc = 0;
        while (!run_done && n_cyc <= 100) begin
            tick();
            n_cyc++;
        end
        chk("timeout_cycles", 64'(n_cyc), 64'd50);
        chk("timeout_flag", 64'(run_timeout), 64'd1);
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        chk("timeout_cleared", 64'(run_timeout), 64'd0);
        repeat (4) tick();

        // Asynchronous reset mid-RUN with a write pending
        chk("run3_comp_enb", 64'(comp_enb), 64'd0);
        mem_write_enb = 1'b1; res_addr = 23'd3; res_data = 64'd77;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_comp_enb", 64'(comp_enb), 64'd1);
        chk("arst_busy", 64'(run_busy), 64'd0);
        chk("arst_wr_count", 64'(wr_count), 64'd0);
        chk("arst_mem_data", mem_data, 64'd0);
        chk("arst_host_rd", host_rd_data, 64'd0);
        mem_write_enb = 1'b0;
        tick();
        rst_n = 1'b1;
        host_rd_addr = 12'd1;
        tick();
        chk("store_survives_rst", host_rd_data, 64'd20);
        mem_read_enb = 1'b1; mem_addr = 23'd4096;
        tick();
        mem_read_enb = 1'b0;
        chk("idle_oor_no_err", 64'(addr_err), 64'd0);
        chk("idle_oor_data", mem_data, 64'd0);

`ifdef ACC_HOST_CHECKSUM_EN
        start_to_run();
        chk("cks_cleared", checksum, 64'd0);
        wr(23'd10, 64'h1);
        wr(23'd11, 64'h2);
        chk("cks_1_2", checksum, 64'h0);
        done = 1'b1;
        tick();
        done = 1'b0;
        start_to_run();
        wr(23'd12, 64'h8000_0000_0000_0000);
        chk("cks_msb", checksum, 64'h8000_0000_0000_0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
